// File: rtl/norm_pkg.sv
// Shared floating-point normalization types and widths: mantissa/exponent sizes,
// the pipeline beat records, and the S2 shift/exponent-adjust function.
package norm_pkg;

  localparam int MANT_W = 16;
  localparam int EXP_W  = 8;
  localparam int LZ_W   = 4;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic [LZ_W-1:0]   lz;
    logic              nz;
  } s1_beat_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    logic              zero;
    logic              underflow;
  } s2_beat_t;

  // When the exponent cannot absorb the full shift, shift only by the exponent.
  // In that branch exp <= lz < 16, so its low LZ_W bits hold the whole amount.
  function automatic s2_beat_t normalize(input s1_beat_t b);
    s2_beat_t         r;
    logic [EXP_W-1:0] lz_ext;
    lz_ext      = {{(EXP_W-LZ_W){1'b0}}, b.lz};
    r.sign      = b.sign;
    r.exp       = '0;
    r.mant      = '0;
    r.zero      = ~b.nz;
    r.underflow = 1'b0;
    if (b.nz) begin
      if (b.exp > lz_ext) begin
        r.mant = b.mant << b.lz;
        r.exp  = b.exp - lz_ext;
      end else begin
        r.mant      = b.mant << b.exp[LZ_W-1:0];
        r.underflow = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lzc_16.sv
// 16-bit leading-zero counter: c = number of leading zeros, v = input nonzero.
// Binary search over halves; c is 15 for a zero input and is qualified by v.
module lzc_16
  import norm_pkg::*;
(
  input  logic [MANT_W-1:0] a,
  output logic [LZ_W-1:0]   c,
  output logic              v
);

  logic [7:0] half8;
  logic [3:0] half4;
  logic [1:0] half2;

  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to remember the old one.
  always_comb begin
    v     = |a;
    c[3]  = ~|a[15:8];
    half8 = c[3] ? a[7:0] : a[15:8];
    c[2]  = ~|half8[7:4];
    half4 = c[2] ? half8[3:0] : half8[7:4];
    c[1]  = ~|half4[3:2];
    half2 = c[1] ? half4[1:0] : half4[3:2];
    c[0]  = ~half2[1];
  end

endmodule

// File: rtl/mant_norm_16.sv
// Two-stage mantissa normalizer with valid/ready handshaking on both sides.
// S1 registers the input plus its leading-zero count; S2 shifts and adjusts the exponent.
module mant_norm_16
  import norm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [MANT_W-1:0] out_mant,
  output logic              out_zero,
  output logic              out_underflow
);

  logic [LZ_W-1:0] lz;
  logic            nz;

  logic     s1_valid_q, s1_valid_d;
  logic     s2_valid_q, s2_valid_d;
  s1_beat_t s1_q, s1_d;
  s2_beat_t s2_q, s2_d;
  logic     s1_adv, s2_adv;

  lzc_16 u_lzc (
    .a (in_mant),
    .c (lz),
    .v (nz)
  );

  // A stage may load when it is empty or its contents move on this same edge.
  always_comb begin
    s2_adv     = ~s2_valid_q | out_ready;
    s1_adv     = ~s1_valid_q | s2_adv;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s1_d       = s1_q;
    s2_d       = s2_q;
    if (s1_adv && in_valid) begin
      s1_d.sign = in_sign;
      s1_d.exp  = in_exp;
      s1_d.mant = in_mant;
      s1_d.lz   = lz;
      s1_d.nz   = nz;
    end
    if (s2_adv && s1_valid_q) begin
      s2_d = normalize(s1_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // NOTE: payload registers are deliberately left out of reset; they are only
  // observed while the matching valid is set.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  assign in_ready      = s1_adv;
  assign out_valid     = s2_valid_q;
  assign out_sign      = s2_q.sign;
  assign out_exp       = s2_q.exp;
  assign out_mant      = s2_q.mant;
  assign out_zero      = s2_q.zero;
  assign out_underflow = s2_q.underflow;

  a_hold_on_stall: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid &&
      $stable({out_sign, out_exp, out_mant, out_zero, out_underflow})));

  a_flags_exclusive: assert property (@(posedge clk) disable iff (rst)
    out_valid |-> !(out_zero && out_underflow));

endmodule

// File: tb/tb_mant_norm_16.sv
// Self-checking bench for mant_norm_16: vector table, backpressure, mid-stream
// reset and a randomized phase, all compared through an expected-result queue.
module tb_mant_norm_16;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] mant;
    logic        zero;
    logic        uf;
  } res_t;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [15:0] mant;
    res_t        want;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [15:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [15:0] out_mant;
  logic        out_zero;
  logic        out_underflow;

  mant_norm_16 dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sign       (in_sign),
    .in_exp        (in_exp),
    .in_mant       (in_mant),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sign      (out_sign),
    .out_exp       (out_exp),
    .out_mant      (out_mant),
    .out_zero      (out_zero),
    .out_underflow (out_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  bit   chk_lat = 1'b0;
  res_t pend;
  res_t sb[$];
  int   acc_q[$];
  vec_t vecs[10];

  task automatic check(input bit ok, input string name, input string msg);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, msg);
  endtask

  function automatic string fmt(input res_t r);
    return $sformatf("s=%0d e=%0d m=%h z=%0d u=%0d", r.sign, r.exp, r.mant, r.zero, r.uf);
  endfunction

  function automatic res_t cur_out();
    res_t r;
    r.sign = out_sign;
    r.exp  = out_exp;
    r.mant = out_mant;
    r.zero = out_zero;
    r.uf   = out_underflow;
    return r;
  endfunction

  // Reference: shift left one step at a time while the exponent allows it.
  function automatic res_t model(input logic s, input logic [7:0] e, input logic [15:0] m);
    res_t r;
    r.sign = s;
    r.zero = 1'b0;
    r.uf   = 1'b0;
    if (m == 16'h0) begin
      r.exp  = 8'd0;
      r.mant = 16'h0;
      r.zero = 1'b1;
    end else begin
      while (!m[15] && e != 8'd0) begin
        m = m << 1;
        e = e - 8'd1;
      end
      r.mant = m;
      r.exp  = e;
      r.uf   = (e == 8'd0);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic s, input logic [7:0] e, input logic [15:0] m,
                              input logic [7:0] we, input logic [15:0] wm,
                              input logic wz, input logic wu);
    vec_t v;
    v.sign      = s;
    v.exp       = e;
    v.mant      = m;
    v.want.sign = s;
    v.want.exp  = we;
    v.want.mant = wm;
    v.want.zero = wz;
    v.want.uf   = wu;
    return v;
  endfunction

  task automatic drive_vec(input vec_t v);
    in_valid = 1'b1;
    in_sign  = v.sign;
    in_exp   = v.exp;
    in_mant  = v.mant;
    pend     = v.want;
  endtask

  task automatic tick(output bit fired);
    res_t act, e;
    int   acc;
    @(negedge clk);
    fired = in_valid && in_ready;
    if (!rst && out_valid && out_ready) begin
      act = cur_out();
      check(sb.size() != 0, "spurious_beat", $sformatf("got %s with nothing expected", fmt(act)));
      if (sb.size() != 0) begin
        e   = sb.pop_front();
        acc = acc_q.pop_front();
        check(act == e, "beat", $sformatf("got %s want %s", fmt(act), fmt(e)));
        if (chk_lat)
          check(cyc - acc == 2, "latency", $sformatf("got %0d want 2", cyc - acc));
      end
    end
    if (!rst && fired) begin
      sb.push_back(pend);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input vec_t v);
    bit f;
    f = 1'b0;
    drive_vec(v);
    for (int g = 0; g < 20 && !f; g++) tick(f);
    check(f, "accept", $sformatf("beat m=%h not accepted in 20 cycles", v.mant));
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit f;
    in_valid = 1'b0;
    for (int g = 0; g < 30 && sb.size() != 0; g++) tick(f);
    check(sb.size() == 0, name, $sformatf("%0d beats still outstanding", sb.size()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    bit          f;
    int          k;
    int          stale;
    logic [15:0] rm;
    logic [7:0]  re;
    logic        rs;

    vecs[0] = mk(1'b0, 8'd20,  16'h0123, 8'd13,  16'h9180, 1'b0, 1'b0);
    vecs[1] = mk(1'b0, 8'd1,   16'h8000, 8'd1,   16'h8000, 1'b0, 1'b0);
    vecs[2] = mk(1'b1, 8'd5,   16'h0001, 8'd0,   16'h0020, 1'b0, 1'b1);
    vecs[3] = mk(1'b0, 8'd8,   16'h00FF, 8'd0,   16'hFF00, 1'b0, 1'b1);
    vecs[4] = mk(1'b1, 8'd99,  16'h0000, 8'd0,   16'h0000, 1'b1, 1'b0);
    vecs[5] = mk(1'b0, 8'd0,   16'h0123, 8'd0,   16'h0123, 1'b0, 1'b1);
    vecs[6] = mk(1'b1, 8'd255, 16'h0001, 8'd240, 16'h8000, 1'b0, 1'b0);
    vecs[7] = mk(1'b0, 8'd9,   16'h00FF, 8'd1,   16'hFF00, 1'b0, 1'b0);
    vecs[8] = mk(1'b0, 8'd0,   16'h0000, 8'd0,   16'h0000, 1'b1, 1'b0);
    vecs[9] = mk(1'b1, 8'd3,   16'h4000, 8'd2,   16'h8000, 1'b0, 1'b0);

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = 8'd0;
    in_mant   = 16'h0;
    out_ready = 1'b0;
    pend      = '0;
    tick(f);
    tick(f);
    check(out_valid == 1'b0, "reset_out_valid", $sformatf("got %0d want 0", out_valid));
    check(in_ready == 1'b1, "reset_in_ready", $sformatf("got %0d want 1", in_ready));
    rst = 1'b0;
    tick(f);

    // Table vectors, back-to-back with no stall: every beat must take 2 cycles.
    chk_lat   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_vec(vecs[i]);
      f = 1'b0;
      for (int g = 0; g < 10 && !f; g++) tick(f);
      check(f, "accept_table", $sformatf("vector %0d not accepted", i));
    end
    drain("drain_table");
    chk_lat = 1'b0;

    // Backpressure: two beats fill the pipe, then hold for three cycles.
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) begin
        check(in_ready == 1'b0, "stall_in_ready", $sformatf("cycle %0d got %0d want 0", c, in_ready));
        check(out_valid == 1'b1 && cur_out() == vecs[0].want, "stall_hold",
              $sformatf("cycle %0d got v=%0d %s want v=1 %s", c, out_valid, fmt(cur_out()),
                        fmt(vecs[0].want)));
      end
      drive_vec(vecs[k]);
      tick(f);
      if (f) k++;
    end
    check(k == 2, "stall_accepted", $sformatf("got %0d want 2", k));
    out_ready = 1'b1;
    for (int g = 0; g < 20 && k < 4; g++) begin
      drive_vec(vecs[k]);
      tick(f);
      if (f) k++;
    end
    check(k == 4, "release_accepted", $sformatf("got %0d want 4", k));
    drain("drain_backpressure");

    // Reset with a full pipe and a beat on the input.
    out_ready = 1'b0;
    for (int i = 4; i < 7; i++) begin
      drive_vec(vecs[i]);
      tick(f);
    end
    drive_vec(vecs[7]);
    rst = 1'b1;
    tick(f);
    sb.delete();
    acc_q.delete();
    check(out_valid == 1'b0, "midrst_out_valid", $sformatf("got %0d want 0", out_valid));
    check(in_ready == 1'b1, "midrst_in_ready", $sformatf("got %0d want 1", in_ready));
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stale     = 0;
    for (int c = 0; c < 6; c++) begin
      tick(f);
      if (out_valid) stale++;
    end
    check(stale == 0, "no_stale_beats", $sformatf("got %0d stale cycles want 0", stale));
    send(vecs[9]);
    drain("drain_after_reset");

    // Random traffic with random backpressure against the reference model.
    for (int c = 0; c < 300; c++) begin
      rm = 16'($urandom) >> $urandom_range(0, 16);
      re = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      rs = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_sign   = rs;
      in_exp    = re;
      in_mant   = rm;
      pend      = model(rs, re, rm);
      out_ready = ($urandom_range(0, 3) != 0);
      tick(f);
    end
    out_ready = 1'b1;
    drain("drain_random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
